// File: rtl/lcd_frame_writer_if.sv
// Pixel-stream and framebuffer-write signals between the PPU side and lcd_frame_writer.
interface lcd_frame_writer_if;
  logic        LCD_EN;
  logic [1:0]  PPU_MODE;
  logic [1:0]  PX_OUT;
  logic        PX_valid;
  logic        FB_WE;
  logic [14:0] FB_ADDR;
  logic [1:0]  FB_DATA;
  logic        FB_BANK;
  logic        DISP_BANK;
  logic        FRAME_DONE;
  logic        ERR_OVERRUN;
  logic        ERR_UNDERRUN;

  modport master (
    output LCD_EN, PPU_MODE, PX_OUT, PX_valid,
    input  FB_WE, FB_ADDR, FB_DATA, FB_BANK, DISP_BANK, FRAME_DONE, ERR_OVERRUN, ERR_UNDERRUN
  );

  modport slave (
    input  LCD_EN, PPU_MODE, PX_OUT, PX_valid,
    output FB_WE, FB_ADDR, FB_DATA, FB_BANK, DISP_BANK, FRAME_DONE, ERR_OVERRUN, ERR_UNDERRUN
  );
endinterface

// File: rtl/lcd_frame_writer.sv
// Writes the PPU pixel stream to a y*FB_W+x framebuffer one cycle after each pixel; no backpressure.
// Bank ping-pong per frame is built only when LCD_FB_DOUBLE_BUFFER_EN is defined.
module lcd_frame_writer #(
  parameter int FB_W = 160,
  parameter int FB_H = 144
) (
  input  logic              clk,
  input  logic              rst,
  lcd_frame_writer_if.slave bus
);
  localparam int XW = $clog2(FB_W + 1);
  localparam int YW = $clog2(FB_H + 1);
  localparam logic [XW-1:0] X_END     = XW'(FB_W);
  localparam logic [YW-1:0] Y_END     = YW'(FB_H);
  localparam logic [14:0]   LINE_STEP = 15'(FB_W);
  localparam logic [1:0]    M_HBLANK  = 2'd0;
  localparam logic [1:0]    M_VBLANK  = 2'd1;
  localparam logic [1:0]    M_SCAN    = 2'd2;
  localparam logic [1:0]    M_DRAW    = 2'd3;

  typedef enum logic [1:0] {IDLE, ACTIVE, LINE_WAIT} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_inc;
  logic [YW-1:0] y_q, y_d;
  logic [14:0]   line_base_q, line_base_d;
  logic [1:0]    prev_mode_q, prev_mode_d;
  logic          fb_we_q, fb_we_d;
  logic [14:0]   fb_addr_q, fb_addr_d;
  logic [1:0]    fb_data_q, fb_data_d;
  logic          frame_done_q, frame_done_d;
  logic          err_ovr_q, err_ovr_d;
  logic          err_und_q, err_und_d;
  logic          vb_entry, line_end, pix;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x_inc        = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    prev_mode_d  = bus.PPU_MODE;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    frame_done_d = 1'b0;
    err_ovr_d    = err_ovr_q;
    err_und_d    = err_und_q;
    vb_entry     = (bus.PPU_MODE == M_VBLANK) && (prev_mode_q != M_VBLANK);
    line_end     = (prev_mode_q == M_DRAW) && (bus.PPU_MODE == M_HBLANK);
    // A pixel arriving on the cycle DRAW ends still belongs to the line.
    pix          = bus.PX_valid && ((bus.PPU_MODE == M_DRAW) || line_end);

    if (!bus.LCD_EN) begin
      state_d     = IDLE;
      x_d         = '0;
      y_d         = '0;
      line_base_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.PPU_MODE == M_VBLANK) state_d = ACTIVE;
        end
        ACTIVE, LINE_WAIT: begin
          if (vb_entry) begin
            frame_done_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
            line_base_d  = '0;
            state_d      = ACTIVE;
            if (y_q != Y_END) err_und_d = 1'b1;
          end else if (state_q == LINE_WAIT &&
                       !(bus.PPU_MODE == M_SCAN || bus.PPU_MODE == M_DRAW)) begin
            state_d = LINE_WAIT;
          end else begin
            state_d = ACTIVE;
            if (pix) begin
              if (x_q < X_END && y_q < Y_END) begin
                fb_we_d   = 1'b1;
                fb_addr_d = line_base_q + 15'(x_q);
                fb_data_d = bus.PX_OUT;
                x_inc     = x_q + 1'b1;
              end else begin
                err_ovr_d = 1'b1;
              end
            end
            x_d = x_inc;
            if (line_end) begin
              if (x_inc < X_END) err_und_d = 1'b1;
              x_d     = '0;
              state_d = LINE_WAIT;
              if (y_q < Y_END) begin
                y_d         = y_q + 1'b1;
                line_base_d = line_base_q + LINE_STEP;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef LCD_FB_DOUBLE_BUFFER_EN
  logic fb_bank_q, fb_bank_d;
  assign fb_bank_d     = fb_bank_q ^ frame_done_d;
  assign bus.FB_BANK   = fb_bank_q;
  assign bus.DISP_BANK = ~fb_bank_q;
`else
  assign bus.FB_BANK   = 1'b0;
  assign bus.DISP_BANK = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      prev_mode_q  <= M_HBLANK;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_ovr_q    <= 1'b0;
      err_und_q    <= 1'b0;
`ifdef LCD_FB_DOUBLE_BUFFER_EN
      fb_bank_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      prev_mode_q  <= prev_mode_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      frame_done_q <= frame_done_d;
      err_ovr_q    <= err_ovr_d;
      err_und_q    <= err_und_d;
`ifdef LCD_FB_DOUBLE_BUFFER_EN
      fb_bank_q    <= fb_bank_d;
`endif
    end
  end

  assign bus.FB_WE        = fb_we_q;
  assign bus.FB_ADDR      = fb_addr_q;
  assign bus.FB_DATA      = fb_data_q;
  assign bus.FRAME_DONE   = frame_done_q;
  assign bus.ERR_OVERRUN  = err_ovr_q;
  assign bus.ERR_UNDERRUN = err_und_q;
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Random pixel traffic for lcd_frame_writer, checked by a scoreboard fed from a y*W+x reference model.
`timescale 1ns/1ps
module tb_lcd_frame_writer;
  localparam int W = 160;
  localparam int H = 144;
  localparam logic [1:0] HB = 2'd0, VB = 2'd1, SC = 2'd2, DR = 2'd3;
`ifdef LCD_FB_DOUBLE_BUFFER_EN
  localparam int DISP_RST = 1;
`else
  localparam int DISP_RST = 0;
`endif

  typedef struct packed { logic [14:0] addr; logic [1:0] data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lcd_frame_writer_if bus_if ();
  lcd_frame_writer #(.FB_W(W), .FB_H(H)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  fd_seen = 0, fd_exp = 0, n_we = 0;
  int  mx = 0, my = 0;
  bit  m_run = 1'b0, ovr_exp = 1'b0, und_exp = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (!rst && bus_if.FRAME_DONE === 1'b1) fd_seen++;
    if (!rst && bus_if.FB_WE === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d with no write expected",
                 bus_if.FB_ADDR, bus_if.FB_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(bus_if.FB_ADDR), int'(mon_e.addr));
        chk("wr_data", int'(bus_if.FB_DATA), int'(mon_e.data));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic en, input logic [1:0] mode, input logic vld, input logic [1:0] px);
    bus_if.LCD_EN   = en;
    bus_if.PPU_MODE = mode;
    bus_if.PX_valid = vld;
    bus_if.PX_OUT   = px;
    @(posedge clk);
    #1;
  endtask

  task automatic model_px(input logic [1:0] p);
    wr_t e;
    if (!m_run) return;
    if (mx < W && my < H) begin
      e.addr = 15'(my * W + mx);
      e.data = p;
      exp_q.push_back(e);
      mx++;
    end else begin
      ovr_exp = 1'b1;
    end
  endtask

  task automatic model_line_end();
    if (!m_run) return;
    if (mx < W) und_exp = 1'b1;
    mx = 0;
    if (my < H) my++;
  endtask

  task automatic do_line(input int npx, input bit coincide, input bit ramp);
    logic [1:0] p;
    for (int i = 0; i < 2; i++) cyc(1'b1, SC, 1'($urandom_range(0, 1)), 2'($urandom));
    cyc(1'b1, DR, 1'b0, 2'd0);
    for (int i = 0; i < npx; i++) begin
      p = ramp ? 2'((i + my) % 4) : 2'($urandom);
      if (coincide && i == npx - 1) begin
        cyc(1'b1, HB, 1'b1, p);
        model_px(p);
        model_line_end();
      end else begin
        if (!ramp && $urandom_range(0, 7) == 0) cyc(1'b1, DR, 1'b0, 2'd0);
        cyc(1'b1, DR, 1'b1, p);
        model_px(p);
      end
    end
    if (!coincide) begin
      cyc(1'b1, HB, 1'b0, 2'd0);
      model_line_end();
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, HB, 1'($urandom_range(0, 1)), 2'($urandom));
  endtask

  task automatic do_vblank(input int n);
    if (m_run) begin
      if (my != H) und_exp = 1'b1;
      fd_exp++;
    end
    m_run = 1'b1;
    mx = 0;
    my = 0;
    cyc(1'b1, VB, 1'b0, 2'd0);
    for (int i = 1; i < n; i++) cyc(1'b1, VB, 1'($urandom_range(0, 1)), 2'($urandom));
  endtask

  task automatic lcd_off(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, DR, 1'b1, 2'($urandom));
    m_run = 1'b0;
    mx = 0;
    my = 0;
  endtask

  task automatic do_reset(input bit drop_pending);
    rst = 1'b1;
    bus_if.LCD_EN = 1'b0; bus_if.PPU_MODE = HB; bus_if.PX_valid = 1'b0; bus_if.PX_OUT = 2'd0;
    if (drop_pending && exp_q.size() > 0) void'(exp_q.pop_back());
    chk("pending_at_reset", exp_q.size(), 0);
    @(negedge clk);
    chk("rst_fb_we", int'(bus_if.FB_WE), 0);
    chk("rst_fb_addr", int'(bus_if.FB_ADDR), 0);
    chk("rst_fb_data", int'(bus_if.FB_DATA), 0);
    chk("rst_fb_bank", int'(bus_if.FB_BANK), 0);
    chk("rst_disp_bank", int'(bus_if.DISP_BANK), DISP_RST);
    chk("rst_frame_done", int'(bus_if.FRAME_DONE), 0);
    chk("rst_err_ovr", int'(bus_if.ERR_OVERRUN), 0);
    chk("rst_err_und", int'(bus_if.ERR_UNDERRUN), 0);
    exp_q.delete();
    m_run = 1'b0; mx = 0; my = 0;
    ovr_exp = 1'b0; und_exp = 1'b0;
    fd_seen = 0; fd_exp = 0; n_we = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic end_check(input string tag);
    for (int i = 0; i < 4; i++) cyc(bus_if.LCD_EN, bus_if.PPU_MODE, 1'b0, 2'd0);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_err_ovr"}, int'(bus_if.ERR_OVERRUN), int'(ovr_exp));
    chk({tag, "_err_und"}, int'(bus_if.ERR_UNDERRUN), int'(und_exp));
    chk({tag, "_frame_done"}, fd_seen, fd_exp);
  endtask

  logic [1:0] p;

  initial begin
    bus_if.LCD_EN = 1'b0; bus_if.PPU_MODE = HB; bus_if.PX_valid = 1'b0; bus_if.PX_OUT = 2'd0;
    #2;
    do_reset(1'b0);

    // Full frame with the (x+y)%4 ramp.
    do_vblank(4);
    for (int l = 0; l < H; l++) do_line(W, 1'b0, 1'b1);
    do_vblank(4);
    end_check("s1");
    chk("s1_writes", n_we, W * H);
`ifdef LCD_FB_DOUBLE_BUFFER_EN
    chk("s1_fb_bank", int'(bus_if.FB_BANK), 1);
    chk("s1_disp_bank", int'(bus_if.DISP_BANK), 0);
    for (int l = 0; l < H; l++) do_line(W, 1'b0, 1'b0);
    do_vblank(4);
    end_check("s6");
    chk("s6_fb_bank", int'(bus_if.FB_BANK), 0);
    chk("s6_disp_bank", int'(bus_if.DISP_BANK), 1);
`endif

    // Surplus pixel on line 5.
    do_reset(1'b0);
    do_vblank(3);
    for (int l = 0; l < 5; l++) do_line(W, 1'b0, 1'b0);
    chk("s2_ovr_before", int'(bus_if.ERR_OVERRUN), int'(ovr_exp));
    do_line(W + 1, 1'b0, 1'b0);
    chk("s2_ovr_after", int'(bus_if.ERR_OVERRUN), int'(ovr_exp));
    do_line(W, 1'b0, 1'b0);
    end_check("s2");

    // Short line 0.
    do_reset(1'b0);
    do_vblank(3);
    do_line(100, 1'b0, 1'b0);
    do_line(W, 1'b0, 1'b0);
    end_check("s3");

    // Last pixel coincident with DRAW->H_BLANK, then reset with a write pending.
    do_reset(1'b0);
    do_vblank(3);
    do_line(W, 1'b1, 1'b0);
    do_line(W, 1'b0, 1'b0);
    end_check("s4");
    cyc(1'b1, SC, 1'b0, 2'd0);
    cyc(1'b1, DR, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      p = 2'($urandom);
      cyc(1'b1, DR, 1'b1, p);
      model_px(p);
    end
    do_reset(1'b1);
    cyc(1'b1, SC, 1'b0, 2'd0);
    for (int i = 0; i < 30; i++) begin
      p = 2'($urandom);
      cyc(1'b1, DR, 1'b1, p);
      model_px(p);
    end
    cyc(1'b1, HB, 1'b0, 2'd0);
    model_line_end();
    end_check("s4_rst");
    chk("s4_rst_writes", n_we, 0);

    // LCD disabled mid-line 70, then restored.
    do_reset(1'b0);
    do_vblank(3);
    for (int l = 0; l < 70; l++) do_line(W, 1'b0, 1'b0);
    cyc(1'b1, SC, 1'b0, 2'd0);
    cyc(1'b1, DR, 1'b0, 2'd0);
    for (int i = 0; i < 50; i++) begin
      p = 2'($urandom);
      cyc(1'b1, DR, 1'b1, p);
      model_px(p);
    end
    lcd_off(5);
    for (int l = 0; l < 2; l++) do_line(W, 1'b0, 1'b0);
    do_vblank(3);
    do_line(W, 1'b0, 1'b0);
    end_check("s5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
